// File: rtl/video_timing_generator.sv
// Raster timing generator: sync/porch/active counters with frame-boundary config latching.
// Outputs are registered from the next-cycle counter values so they line up with h_cnt/v_cnt.
module video_timing_generator #(
  parameter int MAX_WIDTH  = 1920,
  parameter int MAX_HEIGHT = 1080,
  parameter int HW         = 12,
  parameter int VW         = 11
) (
  input  logic                          I_rgb_clk,
  input  logic                          I_rst_n,
  input  logic                          I_enable,
  input  logic [HW-1:0]                 I_h_sync,
  input  logic [HW-1:0]                 I_h_bp,
  input  logic [HW-1:0]                 I_h_active,
  input  logic [HW-1:0]                 I_h_fp,
  input  logic [VW-1:0]                 I_v_sync,
  input  logic [VW-1:0]                 I_v_bp,
  input  logic [VW-1:0]                 I_v_active,
  input  logic [VW-1:0]                 I_v_fp,
  output logic                          O_rgb_de,
  output logic                          O_rgb_hs,
  output logic                          O_rgb_vs,
  output logic [$clog2(MAX_WIDTH)-1:0]  O_x,
  output logic [$clog2(MAX_HEIGHT)-1:0] O_y,
  output logic                          O_new_row,
  output logic                          O_new_frame,
  output logic                          O_frame_done,
  output logic                          O_busy,
  output logic                          O_cfg_error
);

  localparam int XW = $clog2(MAX_WIDTH);
  localparam int YW = $clog2(MAX_HEIGHT);
  localparam int HT = HW + 2;
  localparam int VT = VW + 2;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [HT-1:0] H_LIM = HT'(MAX_WIDTH);
  localparam logic [VT-1:0] V_LIM = VT'(MAX_HEIGHT);

  logic [0:0]    state_q, state_nx;
  logic          rst_q;
  logic [HT-1:0] h_cnt, h_nx;
  logic [VT-1:0] v_cnt, v_nx;
  logic          err_nx, latch;
  logic [HW-1:0] hs_q, hb_q, ha_q, hf_q, hs_n, hb_n, ha_n, hf_n;
  logic [VW-1:0] vs_q, vb_q, va_q, vf_q, vs_n, vb_n, va_n, vf_n;

  logic cfg_ok;
  assign cfg_ok = (I_h_sync != '0) && (I_h_active != '0) &&
                  (I_v_sync != '0) && (I_v_active != '0) &&
                  (HT'(I_h_active) <= H_LIM) && (VT'(I_v_active) <= V_LIM);

  logic [HT-1:0] th_q;
  logic [VT-1:0] tv_q;
  logic          h_last, v_last;
  assign th_q   = HT'(hs_q) + HT'(hb_q) + HT'(ha_q) + HT'(hf_q);
  assign tv_q   = VT'(vs_q) + VT'(vb_q) + VT'(va_q) + VT'(vf_q);
  assign h_last = (h_cnt == th_q - HT'(1));
  assign v_last = (v_cnt == tv_q - VT'(1));

  always_comb begin
    state_nx = state_q;
    h_nx     = h_cnt;
    v_nx     = v_cnt;
    latch    = 1'b0;
    err_nx   = O_cfg_error;
    case (state_q)
      IDLE: begin
        h_nx = '0;
        v_nx = '0;
        if (I_enable && rst_q) begin
          if (cfg_ok) begin
            latch    = 1'b1;
            err_nx   = 1'b0;
            state_nx = RUN;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      default: begin
        if (h_last && v_last) begin
          h_nx = '0;
          v_nx = '0;
          // A failed re-check at the wrap keeps the previous timing running.
          if (I_enable) begin
            latch  = cfg_ok;
            err_nx = !cfg_ok;
          end else begin
            state_nx = IDLE;
          end
        end else if (h_last) begin
          h_nx = '0;
          v_nx = v_cnt + VT'(1);
        end else begin
          h_nx = h_cnt + HT'(1);
        end
      end
    endcase
  end

  assign hs_n = latch ? I_h_sync   : hs_q;
  assign hb_n = latch ? I_h_bp     : hb_q;
  assign ha_n = latch ? I_h_active : ha_q;
  assign hf_n = latch ? I_h_fp     : hf_q;
  assign vs_n = latch ? I_v_sync   : vs_q;
  assign vb_n = latch ? I_v_bp     : vb_q;
  assign va_n = latch ? I_v_active : va_q;
  assign vf_n = latch ? I_v_fp     : vf_q;

  logic [HT-1:0] hsb_n, hae_n, th_n;
  logic [VT-1:0] vsb_n, vae_n, tv_n;
  logic          run_nx, de_d;
  assign hsb_n  = HT'(hs_n) + HT'(hb_n);
  assign hae_n  = hsb_n + HT'(ha_n);
  assign th_n   = hae_n + HT'(hf_n);
  assign vsb_n  = VT'(vs_n) + VT'(vb_n);
  assign vae_n  = vsb_n + VT'(va_n);
  assign tv_n   = vae_n + VT'(vf_n);
  assign run_nx = (state_nx == RUN);
  assign de_d   = run_nx && (h_nx >= hsb_n) && (h_nx < hae_n) &&
                  (v_nx >= vsb_n) && (v_nx < vae_n);

  always_ff @(posedge I_rgb_clk) begin
    if (latch) begin
      hs_q <= I_h_sync;
      hb_q <= I_h_bp;
      ha_q <= I_h_active;
      hf_q <= I_h_fp;
      vs_q <= I_v_sync;
      vb_q <= I_v_bp;
      va_q <= I_v_active;
      vf_q <= I_v_fp;
    end
  end

  always_ff @(posedge I_rgb_clk) begin
    if (!I_rst_n) begin
      state_q      <= IDLE;
      rst_q        <= 1'b0;
      h_cnt        <= '0;
      v_cnt        <= '0;
      O_rgb_de     <= 1'b0;
      O_rgb_hs     <= 1'b0;
      O_rgb_vs     <= 1'b0;
      O_x          <= '0;
      O_y          <= '0;
      O_new_row    <= 1'b0;
      O_new_frame  <= 1'b0;
      O_frame_done <= 1'b0;
      O_busy       <= 1'b0;
      O_cfg_error  <= 1'b0;
    end else begin
      state_q      <= state_nx;
      rst_q        <= 1'b1;
      h_cnt        <= h_nx;
      v_cnt        <= v_nx;
      O_rgb_de     <= de_d;
      O_rgb_hs     <= run_nx && (h_nx < HT'(hs_n));
      O_rgb_vs     <= run_nx && (v_nx < VT'(vs_n));
      O_x          <= de_d ? XW'(h_nx - hsb_n) : '0;
      O_y          <= de_d ? YW'(v_nx - vsb_n) : '0;
      O_new_row    <= run_nx && (h_nx == HT'(hs_n));
      O_new_frame  <= run_nx && (v_nx == VT'(vs_n)) && (h_nx == '0);
      O_frame_done <= run_nx && (h_nx == th_n - HT'(1)) && (v_nx == tv_n - VT'(1));
      O_busy       <= run_nx;
      O_cfg_error  <= err_nx;
    end
  end

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator: a cycle model pushes expected outputs to a scoreboard,
// and each scenario task pops and compares after every clock plus scenario-level counts.
module tb_video_timing_generator;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [11:0] h_s, h_b, h_a, h_f;
  logic [10:0] v_s, v_b, v_a, v_f;
  logic        de, hs, vs, nr, nf, fd, busy, err;
  logic [10:0] ox, oy;

  int n_chk = 0;
  int n_fail = 0;

  logic [29:0] sb[$];
  logic [29:0] got, exp_v;

  video_timing_generator dut (
    .I_rgb_clk(clk), .I_rst_n(rst_n), .I_enable(en),
    .I_h_sync(h_s), .I_h_bp(h_b), .I_h_active(h_a), .I_h_fp(h_f),
    .I_v_sync(v_s), .I_v_bp(v_b), .I_v_active(v_a), .I_v_fp(v_f),
    .O_rgb_de(de), .O_rgb_hs(hs), .O_rgb_vs(vs), .O_x(ox), .O_y(oy),
    .O_new_row(nr), .O_new_frame(nf), .O_frame_done(fd),
    .O_busy(busy), .O_cfg_error(err)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_run, m_rq, m_err;
  int m_h, m_v;
  int c[8];

  task automatic model_tick();
    int th, tv;
    bit ok, go_idle;
    ok = (h_s >= 1) && (v_s >= 1) && (h_a >= 1) && (v_a >= 1) && (h_a <= 1920) && (v_a <= 1080);
    if (!rst_n) begin
      m_run = 0; m_rq = 0; m_err = 0; m_h = 0; m_v = 0;
    end else if (!m_run) begin
      if (en && m_rq) begin
        if (ok) begin
          c = '{int'(h_s), int'(h_b), int'(h_a), int'(h_f), int'(v_s), int'(v_b), int'(v_a), int'(v_f)};
          m_run = 1; m_err = 0;
        end else m_err = 1;
      end
      m_h = 0; m_v = 0; m_rq = 1;
    end else begin
      th = c[0] + c[1] + c[2] + c[3];
      tv = c[4] + c[5] + c[6] + c[7];
      go_idle = 0;
      if (m_h == th - 1 && m_v == tv - 1) begin
        m_h = 0; m_v = 0;
        if (en) begin
          if (ok) begin
            c = '{int'(h_s), int'(h_b), int'(h_a), int'(h_f), int'(v_s), int'(v_b), int'(v_a), int'(v_f)};
            m_err = 0;
          end else m_err = 1;
        end else go_idle = 1;
      end else if (m_h == th - 1) begin
        m_h = 0; m_v = m_v + 1;
      end else m_h = m_h + 1;
      if (go_idle) m_run = 0;
    end
  endtask

  function automatic logic [29:0] model_exp();
    int th, tv;
    logic e_de, e_hs, e_vs, e_nr, e_nf, e_fd;
    logic [10:0] ex, ey;
    if (!m_run) return {1'b0, m_err, 28'd0};
    th = c[0] + c[1] + c[2] + c[3];
    tv = c[4] + c[5] + c[6] + c[7];
    e_hs = (m_h < c[0]);
    e_vs = (m_v < c[4]);
    e_de = (m_h >= c[0] + c[1]) && (m_h < c[0] + c[1] + c[2]) &&
           (m_v >= c[4] + c[5]) && (m_v < c[4] + c[5] + c[6]);
    ex = e_de ? 11'(m_h - c[0] - c[1]) : 11'd0;
    ey = e_de ? 11'(m_v - c[4] - c[5]) : 11'd0;
    e_nr = (m_h == c[0]);
    e_nf = (m_v == c[4]) && (m_h == 0);
    e_fd = (m_h == th - 1) && (m_v == tv - 1);
    return {1'b1, m_err, e_de, e_hs, e_vs, e_nr, e_nf, e_fd, ex, ey};
  endfunction

  function automatic logic [29:0] dut_vec();
    return {busy, err, de, hs, vs, nr, nf, fd, ox, oy};
  endfunction

  // Drive one clock: model predicts, expectation queued, DUT sampled 1ns after the edge.
  task automatic advance();
    model_tick();
    sb.push_back(model_exp());
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int a0, a1, a2, a3, b0, b1, b2, b3);
    h_s = 12'(a0); h_b = 12'(a1); h_a = 12'(a2); h_f = 12'(a3);
    v_s = 11'(b0); v_b = 11'(b1); v_a = 11'(b2); v_f = 11'(b3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    set_cfg(2, 3, 8, 1, 1, 1, 4, 1);
    for (int i = 0; i < 4; i++) begin
      advance();
      got = dut_vec(); exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL reset_cyc%0d got=%h exp=%h", i, got, exp_v); end
    end
    n_chk++;
    if (dut_vec() !== 30'd0) begin n_fail++; $display("FAIL reset_zero got=%h exp=0", dut_vec()); end
    rst_n = 1'b1;
    advance();
    got = dut_vec(); exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL release_cyc got=%h exp=%h", got, exp_v); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL release_first_edge busy=%b exp=0", busy); end
    advance();
    got = dut_vec(); exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL start_cyc got=%h exp=%h", got, exp_v); end
    n_chk++;
    if ({busy, hs, vs, de} !== 4'b1110) begin
      n_fail++; $display("FAIL start_state busy/hs/vs/de=%b exp=1110", {busy, hs, vs, de});
    end
  endtask

  task automatic test_basic_frame();
    int nde = 0, nnr = 0, nnf = 0, nfd = 0, xmax = 0, ymax = 0, first = -1;
    for (int i = 0; i < 98; i++) begin
      nde += de; nnr += nr; nnf += nf; nfd += fd;
      if (de && first < 0) first = i;
      if (de && int'(ox) > xmax) xmax = int'(ox);
      if (de && int'(oy) > ymax) ymax = int'(oy);
      advance();
      got = dut_vec(); exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL basic_cyc%0d got=%h exp=%h", i, got, exp_v); end
    end
    n_chk++; if (nde !== 32) begin n_fail++; $display("FAIL basic_de_count got=%0d exp=32", nde); end
    n_chk++; if (nnr !== 7) begin n_fail++; $display("FAIL basic_new_row got=%0d exp=7", nnr); end
    n_chk++; if (nnf !== 1) begin n_fail++; $display("FAIL basic_new_frame got=%0d exp=1", nnf); end
    n_chk++; if (nfd !== 1) begin n_fail++; $display("FAIL basic_frame_done got=%0d exp=1", nfd); end
    n_chk++; if (xmax !== 7 || ymax !== 3) begin n_fail++; $display("FAIL basic_xy_max got=%0d/%0d exp=7/3", xmax, ymax); end
    n_chk++; if (first !== 33) begin n_fail++; $display("FAIL basic_first_de got=%0d exp=33", first); end
    n_chk++; if ({busy, hs, vs} !== 3'b111) begin n_fail++; $display("FAIL basic_no_gap got=%b exp=111", {busy, hs, vs}); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 98; i++) begin
      advance();
      got = dut_vec(); exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL b2b_cyc%0d got=%h exp=%h", i, got, exp_v); end
    end
  endtask

  task automatic test_disable();
    int nbusy = 0;
    for (int i = 0; i < 110; i++) begin
      if (i == 40) en = 1'b0;
      nbusy += busy;
      advance();
      got = dut_vec(); exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL disable_cyc%0d got=%h exp=%h", i, got, exp_v); end
    end
    n_chk++; if (nbusy !== 98) begin n_fail++; $display("FAIL disable_busy_cycles got=%0d exp=98", nbusy); end
    n_chk++; if (dut_vec() !== 30'd0) begin n_fail++; $display("FAIL disable_idle_outputs got=%h exp=0", dut_vec()); end
  endtask

  task automatic test_cfg_error();
    h_a = 12'd0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      advance();
      got = dut_vec(); exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL cfgerr_cyc%0d got=%h exp=%h", i, got, exp_v); end
    end
    n_chk++; if ({busy, err} !== 2'b01) begin n_fail++; $display("FAIL cfgerr_flag busy/err=%b exp=01", {busy, err}); end
    h_a = 12'd8;
    advance();
    got = dut_vec(); exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL cfgfix_cyc got=%h exp=%h", got, exp_v); end
    n_chk++; if ({busy, err} !== 2'b10) begin n_fail++; $display("FAIL cfgfix_flag busy/err=%b exp=10", {busy, err}); end
  endtask

  task automatic run_frame(input string nm, input int cfg_at, input bit restore,
                           output int len, output int nde);
    bit done = 0;
    len = 0; nde = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (i == cfg_at) begin
        if (restore) begin h_s = 12'd2; h_a = 12'd8; end
        else h_s = 12'd0;
      end
      nde += de;
      if (fd) begin done = 1; len = i + 1; end
      advance();
      got = dut_vec(); exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL %s_cyc%0d got=%h exp=%h", nm, i, got, exp_v); end
    end
    n_chk++;
    if (!done) begin n_fail++; $display("FAIL %s_timeout frame_done=0 exp=1", nm); end
  endtask

  task automatic test_cfg_change();
    int len, nde;
    nde = 0;
    for (int i = 0; i < 98; i++) begin
      if (i == 30) h_a = 12'd4;
      nde += de;
      advance();
      got = dut_vec(); exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL chg1_cyc%0d got=%h exp=%h", i, got, exp_v); end
    end
    n_chk++; if (nde !== 32) begin n_fail++; $display("FAIL chg_cur_frame_de got=%0d exp=32", nde); end
    run_frame("chg2", 10, 1'b0, len, nde);
    n_chk++; if (len !== 70) begin n_fail++; $display("FAIL chg_next_len got=%0d exp=70", len); end
    n_chk++; if (nde !== 16) begin n_fail++; $display("FAIL chg_next_de got=%0d exp=16", nde); end
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL wrap_invalid_err got=%b exp=1", err); end
    run_frame("chg3", 10, 1'b1, len, nde);
    n_chk++; if (len !== 70) begin n_fail++; $display("FAIL wrap_old_cfg_len got=%0d exp=70", len); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL wrap_valid_err got=%b exp=0", err); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 50; i++) begin
      advance();
      got = dut_vec(); exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL rstmid_cyc%0d got=%h exp=%h", i, got, exp_v); end
    end
    rst_n = 1'b0;
    advance();
    got = dut_vec(); exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL rstmid_hit got=%h exp=%h", got, exp_v); end
    n_chk++; if (dut_vec() !== 30'd0) begin n_fail++; $display("FAIL rstmid_zero got=%h exp=0", dut_vec()); end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      advance();
      got = dut_vec(); exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL rstmid_rel%0d got=%h exp=%h", i, got, exp_v); end
    end
    n_chk++;
    if ({busy, hs, vs, de, nr, nf} !== 6'b111000) begin
      n_fail++; $display("FAIL rstmid_restart got=%b exp=111000", {busy, hs, vs, de, nr, nf});
    end
  endtask

  task automatic test_zero_porch();
    int len, nde, first = -1;
    bit nr_first = 0;
    set_cfg(1, 0, 3, 0, 1, 0, 2, 0);
    run_frame("zp_wait", -1, 1'b0, len, nde);
    nde = 0;
    for (int i = 0; i < 12; i++) begin
      nde += de;
      if (de && first < 0) begin first = i; nr_first = nr; end
      advance();
      got = dut_vec(); exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL zp_cyc%0d got=%h exp=%h", i, got, exp_v); end
    end
    n_chk++; if (first !== 5) begin n_fail++; $display("FAIL zp_first_de got=%0d exp=5", first); end
    n_chk++; if (nr_first !== 1'b1) begin n_fail++; $display("FAIL zp_row_de_coincide got=%b exp=1", nr_first); end
    n_chk++; if (nde !== 6) begin n_fail++; $display("FAIL zp_de_count got=%0d exp=6", nde); end
  endtask

  initial begin
    m_run = 0; m_rq = 0; m_err = 0; m_h = 0; m_v = 0;
    c = '{1, 0, 1, 0, 1, 0, 1, 0};
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_disable();
    test_cfg_error();
    test_cfg_change();
    test_reset_mid();
    test_zero_porch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_generator.md
VIDEO_TIMING_GENERATOR -- requirements
Module: Video_Timing_Generator

Interface
REQ-001 SHALL have parameters MAX_WIDTH (default 1920), the maximum active pixels per line, and MAX_HEIGHT (default 1080), the maximum active lines per frame.
REQ-002 SHALL have parameters HW (default 12), the width of each horizontal config field, and VW (default 11), the width of each vertical config field.
REQ-003 SHALL have port I_rgb_clk, input, 1 bit: the single pixel clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port I_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port I_enable, input, 1 bit: run request.
REQ-006 SHALL have ports I_h_sync, I_h_bp, I_h_active and I_h_fp, inputs, HW bits each: horizontal sync, back-porch, active and front-porch lengths in clocks.
REQ-007 SHALL have ports I_v_sync, I_v_bp, I_v_active and I_v_fp, inputs, VW bits each: vertical sync, back-porch, active and front-porch lengths in lines.
REQ-008 SHALL have ports O_rgb_de, O_rgb_hs and O_rgb_vs, outputs, 1 bit each: data enable, hsync and vsync; both syncs are active-high.
REQ-009 SHALL have ports O_x and O_y, outputs, $clog2(MAX_WIDTH) and $clog2(MAX_HEIGHT) bits: active pixel coordinates.
REQ-010 SHALL have ports O_new_row and O_new_frame, outputs, 1 bit each: single-cycle pulses at sync falling edges.
REQ-011 SHALL have ports O_frame_done, O_busy and O_cfg_error, outputs, 1 bit each: last-cycle-of-frame pulse, running flag and config error flag.

Function
REQ-012 SHALL implement states IDLE and RUN; O_busy SHALL be 1 exactly in RUN.
REQ-013 Config SHALL be valid iff all of: sync >= 1; active >= 1; I_h_active <= MAX_WIDTH; I_v_active <= MAX_HEIGHT.
REQ-014 IDLE with I_enable=1 and valid config: latch all eight fields, set h_cnt=0 and v_cnt=0, clear O_cfg_error, go to RUN; first RUN cycle is line 0, clock 0.
REQ-015 IDLE with I_enable=1 and invalid config: set O_cfg_error=1, stay IDLE; the check re-evaluates every cycle.
REQ-016 Line layout by h_cnt: [0,S) sync; [S,S+B) back porch; [S+B,S+B+A) active; [S+B+A,T) front porch; T = S+B+A+F.
REQ-017 Frame layout SHALL be the same ordering by v_cnt.
REQ-018 Totals SHALL be computed at HW+2 and VW+2 bits, without overflow.
REQ-019 h_cnt SHALL wrap from T_h-1 to 0 and increment v_cnt; v_cnt SHALL wrap from T_v-1 to 0.
REQ-020 All outputs SHALL be registers reflecting the current (h_cnt,v_cnt) in the same cycle.
REQ-021 O_rgb_hs=1 iff h_cnt<S_h; O_rgb_vs=1 iff v_cnt<S_v, changing only at h_cnt=0.
REQ-022 O_rgb_de=1 iff both counters are in their active regions.
REQ-023 O_x=h_cnt-(S_h+B_h) and O_y=v_cnt-(S_v+B_v) while O_rgb_de=1; both 0 otherwise.
REQ-024 O_new_row=1 for one cycle at h_cnt==S_h (first cycle with hs low).
REQ-025 O_new_frame=1 for one cycle at v_cnt==S_v and h_cnt==0.
REQ-026 O_frame_done=1 for one cycle at h_cnt==T_h-1 and v_cnt==T_v-1.
REQ-027 At frame wrap with I_enable=1: re-latch config if valid and continue RUN with no gap cycle; if invalid, keep the old config and set O_cfg_error=1.
REQ-028 Config input changes mid-frame SHALL take effect only at the next frame wrap.
REQ-029 I_enable=0 in RUN SHALL let the current frame complete; at the wrap the block SHALL enter IDLE instead.
REQ-030 I_enable re-asserted before the wrap SHALL continue RUN uninterrupted.
REQ-031 In IDLE, de, hs, vs, the pulses, O_x and O_y SHALL all be 0.
REQ-032 Zero porches (B=0 or F=0) SHALL be supported; sync is then adjacent to active.

Reset
REQ-033 I_rst_n=0 at any clock edge, including mid-frame, SHALL force IDLE and h_cnt=v_cnt=0.
REQ-034 Under reset, all outputs SHALL be 0, O_cfg_error included.
REQ-035 The first RUN cycle is no earlier than the second edge after reset release with I_enable=1.

Verification
REQ-036 Config h=2/3/8/1 (T=14), v=1/1/4/1 (T=7), enable held: frame = 98 clocks; per frame 32 de cycles, 7 O_new_row pulses, 1 O_new_frame, 1 O_frame_done; O_x runs 0..7, O_y 0..3; first de at h_cnt=5, v_cnt=2.
REQ-037 Same config, I_enable dropped at clock 40 of frame: frame ends at clock 97, O_busy=0 from clock 98, all outputs 0.
REQ-038 I_h_active=0 with enable: stays IDLE, O_cfg_error=1; set I_h_active=8: RUN next cycle, O_cfg_error=0.
REQ-039 I_h_active changed 8->4 at clock 30: current frame still has 32 de cycles; next frame has 16, with T_h=10.
REQ-040 Reset pulsed at clock 50: outputs 0 on the next edge; after release, timing restarts at h_cnt=0, v_cnt=0.
REQ-041 h=1/0/3/0, v=1/0/2/0: de begins immediately after hs falls; O_new_row and the first de cycle are coincident.
